// File: rtl/usb_rx_pkt_ctrl_if.sv
// usb_rx_pkt_ctrl_if
// Bundles the device core's OUT-data receive signals and the packet FIFO
// write-side port set. The slave modport is the sequencer's view. The
// master modport is the view of the core/FIFO side driving it.
interface usb_rx_pkt_ctrl_if #(
    parameter int ASIZE = 9
);
    logic             rx_act;
    logic             rx_val;
    logic [7:0]       rx_dat;
    logic             rx_pktval;
    logic [ASIZE:0]   fifo_wrnum;
    logic             fifo_full;
    logic             fifo_write;
    logic [7:0]       fifo_wdat;
    logic             fifo_pktval;
    logic             fifo_rxact;

    modport master (
        output rx_act, rx_val, rx_dat, rx_pktval, fifo_wrnum, fifo_full,
        input  fifo_write, fifo_wdat, fifo_pktval, fifo_rxact
    );

    modport slave (
        input  rx_act, rx_val, rx_dat, rx_pktval, fifo_wrnum, fifo_full,
        output fifo_write, fifo_wdat, fifo_pktval, fifo_rxact
    );
endinterface

// File: rtl/usb_rx_pkt_ctrl.sv
// usb_rx_pkt_ctrl
// Receive-side sequencer between the USB core's OUT-data receive interface
// and the packet FIFO. Received bytes pass through a two-stage write pipe.
// At the end of each packet the sequencer either commits the packet with a
// pktval strobe or abandons it. An abandoned packet is rewound by the FIFO
// on the next rx_act rise.
// Optional feature macro: RX_STAT_CNT_EN. When it is defined, ok_cnt and
// drop_cnt are saturating counters. When it is undefined, both are tied
// to zero.
module usb_rx_pkt_ctrl #(
    parameter int ASIZE  = 9,
    parameter int MAXPKT = 64
) (
    input  logic              CLK,
    input  logic              RSTn,
    usb_rx_pkt_ctrl_if.slave  bus,
    output logic              rx_ready,
    output logic [ASIZE:0]    pkt_len,
    output logic              pkt_ok,
    output logic              pkt_err,
    output logic [15:0]       ok_cnt,
    output logic [15:0]       drop_cnt
);
    localparam int               DEPTH   = 1 << ASIZE;
    localparam logic [ASIZE:0]   MAX_LEN = (ASIZE+1)'(MAXPKT);
    localparam logic [ASIZE+1:0] DEPTH_W = (ASIZE+2)'(DEPTH);
    localparam logic [ASIZE+1:0] MAX_W   = (ASIZE+2)'(MAXPKT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECV,
        ST_FLUSH1,
        ST_FLUSH2,
        ST_END
    } state_t;

    // Free space check is done one bit wider than wrnum so that a full
    // FIFO (wrnum = DEPTH) still yields a non-negative result.
    function automatic logic space_ok(input logic [ASIZE:0] wrnum);
        logic [ASIZE+1:0] space;
        space = DEPTH_W - {1'b0, wrnum};
        return (space >= MAX_W);
    endfunction

    state_t         state;
    logic [ASIZE:0] cnt;
    logic           err;
    logic           good;
    logic           viol;
    logic           pktval_r;

    logic           vld_p0;
    logic [7:0]     dat_p0;
    logic           vld_p1;
    logic [7:0]     dat_p1;

    logic           byte_in;
    logic           accept;
    logic           overrun;
    logic           full_drop;

    // A byte counts only while the packet is open, and only in RECV.
    assign byte_in   = (state == ST_RECV) && bus.rx_act && bus.rx_val;
    assign accept    = byte_in && (cnt < MAX_LEN);
    assign overrun   = byte_in && (cnt >= MAX_LEN);
    assign full_drop = vld_p0 && bus.fifo_full;

    // Packet sequencer: tracks length, error and CRC-good status, and
    // issues the commit or drop decision in the END cycle.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            err      <= 1'b0;
            good     <= 1'b0;
            viol     <= 1'b0;
            pktval_r <= 1'b0;
            pkt_ok   <= 1'b0;
            pkt_err  <= 1'b0;
            pkt_len  <= '0;
        end else begin
            pktval_r <= 1'b0;
            pkt_ok   <= 1'b0;
            pkt_err  <= 1'b0;
            if (full_drop) begin
                err <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    viol <= 1'b0;
                    if (bus.rx_act) begin
                        // A packet that opened during the previous packet's
                        // flush has already lost bytes, so it is doomed.
                        state <= ST_RECV;
                        cnt   <= '0;
                        err   <= viol;
                        good  <= bus.rx_pktval;
                    end
                end
                ST_RECV: begin
                    if (accept) begin
                        cnt <= cnt + 1'b1;
                    end
                    if (overrun) begin
                        err <= 1'b1;
                    end
                    if (bus.rx_pktval) begin
                        good <= 1'b1;
                    end
                    if (!bus.rx_act) begin
                        state <= ST_FLUSH1;
                    end
                end
                ST_FLUSH1: begin
                    if (bus.rx_act) begin
                        viol <= 1'b1;
                    end
                    state <= ST_FLUSH2;
                end
                ST_FLUSH2: begin
                    if (bus.rx_act) begin
                        viol <= 1'b1;
                    end
                    state   <= ST_END;
                    pkt_len <= cnt;
                    if (good && !err) begin
                        pktval_r <= 1'b1;
                        pkt_ok   <= 1'b1;
                    end else begin
                        pkt_err  <= 1'b1;
                    end
                end
                ST_END: begin
                    if (bus.rx_act) begin
                        viol <= 1'b1;
                    end
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Two-stage write pipe. The delay keeps the first write behind the FIFO
    // rewind. The last stage drops the write when the FIFO is full.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            vld_p0 <= 1'b0;
            dat_p0 <= '0;
            vld_p1 <= 1'b0;
            dat_p1 <= '0;
        end else begin
            vld_p0 <= accept;
            if (accept) begin
                dat_p0 <= bus.rx_dat;
            end
            vld_p1 <= vld_p0 && !bus.fifo_full;
            dat_p1 <= dat_p0;
        end
    end

    // Space-available flag for ACK/NAK decisions, one cycle behind wrnum.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            rx_ready <= 1'b0;
        end else begin
            rx_ready <= space_ok(bus.fifo_wrnum);
        end
    end

    assign bus.fifo_write  = vld_p1;
    assign bus.fifo_wdat   = dat_p1;
    assign bus.fifo_pktval = pktval_r;
    assign bus.fifo_rxact  = bus.rx_act;

`ifdef RX_STAT_CNT_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

    logic [15:0] ok_cnt_r;
    logic [15:0] drop_cnt_r;
    logic        decide;

    assign decide = (state == ST_FLUSH2);

    // Saturating per-packet statistics, updated with the END decision.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            ok_cnt_r   <= '0;
            drop_cnt_r <= '0;
        end else if (decide) begin
            if (good && !err) begin
                ok_cnt_r <= sat_inc(ok_cnt_r);
            end else begin
                drop_cnt_r <= sat_inc(drop_cnt_r);
            end
        end
    end

    assign ok_cnt   = ok_cnt_r;
    assign drop_cnt = drop_cnt_r;
`else
    assign ok_cnt   = 16'h0000;
    assign drop_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_usb_rx_pkt_ctrl.sv
// tb_usb_rx_pkt_ctrl
// Directed bench for usb_rx_pkt_ctrl with ASIZE=9 and MAXPKT=64.
// Expected counter values depend on whether RX_STAT_CNT_EN is defined.
module tb_usb_rx_pkt_ctrl;
    localparam int ASIZE  = 9;
    localparam int MAXPKT = 64;

`ifdef RX_STAT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic              CLK = 1'b0;
    logic              RSTn = 1'b0;
    logic              rx_ready;
    logic [ASIZE:0]    pkt_len;
    logic              pkt_ok;
    logic              pkt_err;
    logic [15:0]       ok_cnt;
    logic [15:0]       drop_cnt;

    usb_rx_pkt_ctrl_if #(.ASIZE(ASIZE)) bus ();

    usb_rx_pkt_ctrl #(.ASIZE(ASIZE), .MAXPKT(MAXPKT)) dut (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .bus      (bus),
        .rx_ready (rx_ready),
        .pkt_len  (pkt_len),
        .pkt_ok   (pkt_ok),
        .pkt_err  (pkt_err),
        .ok_cnt   (ok_cnt),
        .drop_cnt (drop_cnt)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Monitor: logs every FIFO write and counts strobes.
    logic [7:0] w_dat[$];
    int         w_cyc[$];
    int         n_pv = 0;
    int         n_ok = 0;
    int         n_er = 0;
    int         pv_cyc = 0;
    always @(negedge CLK) begin
        if (bus.fifo_write === 1'b1) begin
            w_dat.push_back(bus.fifo_wdat);
            w_cyc.push_back(cyc);
        end
        if (bus.fifo_pktval === 1'b1) begin
            n_pv   <= n_pv + 1;
            pv_cyc <= cyc;
        end
        if (pkt_ok === 1'b1) n_ok <= n_ok + 1;
        if (pkt_err === 1'b1) n_er <= n_er + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt(input int v);
        return CNT_EN ? 32'(v) : 32'd0;
    endfunction

    int w0, pv0, ok0, er0;
    task automatic snap();
        w0  = w_dat.size();
        pv0 = n_pv;
        ok0 = n_ok;
        er0 = n_er;
    endtask

    int d_cyc[$];
    int rise_cyc;
    int fall_cyc;

    // Full packet: rise, n bytes back to back, fall, then drain past END.
    task automatic send_pkt(input int n, input logic [7:0] base, input bit good, input int full_at);
        snap();
        d_cyc.delete();
        @(negedge CLK);
        bus.rx_act = 1'b1;
        rise_cyc   = cyc;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            bus.rx_val    = 1'b1;
            bus.rx_dat    = base + 8'(i);
            bus.rx_pktval = good && (i == n - 1);
            if (i == full_at) bus.fifo_full = 1'b1;
            d_cyc.push_back(cyc);
        end
        @(negedge CLK);
        bus.rx_val    = 1'b0;
        bus.rx_pktval = good && (n == 0);
        bus.rx_act    = 1'b0;
        fall_cyc      = cyc;
        @(negedge CLK);
        bus.rx_pktval = 1'b0;
        repeat (6) @(negedge CLK);
        bus.fifo_full = 1'b0;
    endtask

    int wr_at_rst;
    int fw;

    initial begin
        bus.rx_act     = 1'b0;
        bus.rx_val     = 1'b0;
        bus.rx_dat     = 8'h00;
        bus.rx_pktval  = 1'b0;
        bus.fifo_wrnum = '0;
        bus.fifo_full  = 1'b0;

        // Reset state.
        repeat (2) @(negedge CLK);
        check("rst_write",  32'(bus.fifo_write),  32'd0);
        check("rst_pktval", 32'(bus.fifo_pktval), 32'd0);
        check("rst_ok",     32'(pkt_ok),          32'd0);
        check("rst_err",    32'(pkt_err),         32'd0);
        check("rst_len",    32'(pkt_len),         32'd0);
        check("rst_ready",  32'(rx_ready),        32'd0);
        check("rst_okcnt",  32'(ok_cnt),          32'd0);
        check("rst_dropcnt", 32'(drop_cnt),       32'd0);
        check("rst_rxact0", 32'(bus.fifo_rxact),  32'd0);
        bus.rx_act = 1'b1;
        #1;
        check("rst_rxact1", 32'(bus.fifo_rxact),  32'd1);
        bus.rx_act = 1'b0;
        @(negedge CLK);
        RSTn = 1'b1;
        repeat (2) @(negedge CLK);
        check("ready_empty", 32'(rx_ready), 32'd1);

        // Good packet 0x01..0x0A.
        send_pkt(10, 8'h01, 1'b1, -1);
        check("p1_nwrite", 32'(w_dat.size() - w0), 32'd10);
        for (int i = 0; i < 10 && (w0 + i) < w_dat.size(); i++) begin
            check($sformatf("p1_dat%0d", i), 32'(w_dat[w0 + i]), 32'(i + 1));
            check($sformatf("p1_lat%0d", i), 32'(w_cyc[w0 + i] - d_cyc[i]), 32'd2);
        end
        check("p1_npv",    32'(n_pv - pv0),        32'd1);
        check("p1_pvlat",  32'(pv_cyc - fall_cyc), 32'd3);
        check("p1_ok",     32'(n_ok - ok0),        32'd1);
        check("p1_err",    32'(n_er - er0),        32'd0);
        check("p1_len",    32'(pkt_len),           32'd10);
        check("p1_okcnt",  32'(ok_cnt),            exp_cnt(1));

        // Bad CRC: 8 bytes, no rx_pktval.
        send_pkt(8, 8'h20, 1'b0, -1);
        check("p2_nwrite", 32'(w_dat.size() - w0), 32'd8);
        check("p2_npv",    32'(n_pv - pv0),        32'd0);
        check("p2_err",    32'(n_er - er0),        32'd1);
        check("p2_ok",     32'(n_ok - ok0),        32'd0);
        check("p2_len",    32'(pkt_len),           32'd8);
        check("p2_dropcnt", 32'(drop_cnt),         exp_cnt(1));

        // Oversize: 70 bytes with good CRC, only MAXPKT written.
        send_pkt(70, 8'h40, 1'b1, -1);
        check("p3_nwrite", 32'(w_dat.size() - w0), 32'd64);
        fw = (w_dat.size() > w0) ? w_cyc[w0] : -1000;
        check("p3_firstwr", 32'(fw - rise_cyc), 32'd3);
        if (w_dat.size() >= w0 + 64)
            check("p3_lastdat", 32'(w_dat[w0 + 63]), 32'h7F);
        check("p3_npv",    32'(n_pv - pv0),        32'd0);
        check("p3_err",    32'(n_er - er0),        32'd1);
        check("p3_len",    32'(pkt_len),           32'd64);
        check("p3_dropcnt", 32'(drop_cnt),         exp_cnt(2));

        // FIFO full after 5 writes.
        send_pkt(10, 8'h80, 1'b1, 6);
        check("p4_nwrite", 32'(w_dat.size() - w0), 32'd5);
        check("p4_npv",    32'(n_pv - pv0),        32'd0);
        check("p4_err",    32'(n_er - er0),        32'd1);
        check("p4_len",    32'(pkt_len),           32'd10);
        check("p4_dropcnt", 32'(drop_cnt),         exp_cnt(3));

        // Zero-length good packet commits.
        send_pkt(0, 8'h00, 1'b1, -1);
        check("p5_nwrite", 32'(w_dat.size() - w0), 32'd0);
        check("p5_npv",    32'(n_pv - pv0),        32'd1);
        check("p5_ok",     32'(n_ok - ok0),        32'd1);
        check("p5_len",    32'(pkt_len),           32'd0);
        check("p5_okcnt",  32'(ok_cnt),            exp_cnt(2));

        // rx_ready threshold and lag.
        @(negedge CLK);
        bus.fifo_wrnum = 10'd448;
        @(negedge CLK);
        check("rdy_448", 32'(rx_ready), 32'd1);
        bus.fifo_wrnum = 10'd449;
        #1;
        check("rdy_449_lag", 32'(rx_ready), 32'd1);
        @(negedge CLK);
        check("rdy_449", 32'(rx_ready), 32'd0);
        bus.fifo_wrnum = 10'd512;
        @(negedge CLK);
        check("rdy_512", 32'(rx_ready), 32'd0);
        bus.fifo_wrnum = 10'd0;
        @(negedge CLK);
        check("rdy_0", 32'(rx_ready), 32'd1);

        // Back-to-back violation: second packet rises in FLUSH2.
        snap();
        @(negedge CLK);
        bus.rx_act = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            bus.rx_val    = 1'b1;
            bus.rx_dat    = 8'h10 + 8'(i);
            bus.rx_pktval = (i == 2);
        end
        @(negedge CLK);
        bus.rx_val    = 1'b0;
        bus.rx_pktval = 1'b0;
        bus.rx_act    = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        bus.rx_act = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            bus.rx_val    = 1'b1;
            bus.rx_dat    = 8'h30 + 8'(i);
            bus.rx_pktval = (i == 5);
        end
        @(negedge CLK);
        bus.rx_val    = 1'b0;
        bus.rx_pktval = 1'b0;
        bus.rx_act    = 1'b0;
        repeat (7) @(negedge CLK);
        check("v_nwrite",  32'(w_dat.size() - w0), 32'd7);
        if (w_dat.size() >= w0 + 4)
            check("v_2nd_first", 32'(w_dat[w0 + 3]), 32'h32);
        check("v_npv",     32'(n_pv - pv0),        32'd1);
        check("v_ok",      32'(n_ok - ok0),        32'd1);
        check("v_err",     32'(n_er - er0),        32'd1);
        check("v_len",     32'(pkt_len),           32'd4);
        check("v_okcnt",   32'(ok_cnt),            exp_cnt(3));
        check("v_dropcnt", 32'(drop_cnt),          exp_cnt(4));

        // Reset asserted mid-packet.
        snap();
        @(negedge CLK);
        bus.rx_act = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            bus.rx_val = 1'b1;
            bus.rx_dat = 8'hA0 + 8'(i);
        end
        @(negedge CLK);
        RSTn       = 1'b0;
        bus.rx_val = 1'b0;
        bus.rx_act = 1'b0;
        #1;
        wr_at_rst = w_dat.size();
        check("mr_write",   32'(bus.fifo_write), 32'd0);
        check("mr_wdat",    32'(bus.fifo_wdat),  32'd0);
        check("mr_len",     32'(pkt_len),        32'd0);
        check("mr_okcnt",   32'(ok_cnt),         32'd0);
        check("mr_dropcnt", 32'(drop_cnt),       32'd0);
        repeat (2) @(negedge CLK);
        RSTn = 1'b1;
        repeat (6) @(negedge CLK);
        check("mr_nwrite",  32'(w_dat.size() - wr_at_rst), 32'd0);
        check("mr_npv",     32'(n_pv - pv0), 32'd0);
        check("mr_ok",      32'(n_ok - ok0), 32'd0);
        check("mr_err",     32'(n_er - er0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/usb_rx_pkt_ctrl.md
# usb_rx_pkt_ctrl

- Receive-side sequencer that sits between the USB device core's OUT-data receive interface and the packet FIFO (write/pktval/rxact port set, wrnum/full status).
- Pipelines received bytes into the FIFO and decides per packet whether to commit it (pktval pulse) or abandon it. An abandoned packet is discarded by the FIFO's rewind on the next rxact rise.
- Publishes a space-available flag for ACK/NAK, plus per-packet status pulses.

## Interface
Parameters:
- ASIZE, 9: FIFO address width; depth = 2^ASIZE bytes.
- MAXPKT, 64: maximum accepted payload bytes per packet; 1..2^ASIZE.

Ports:
- CLK  in  1  single clock for all logic.
- RSTn  in  1  reset, asynchronous, active-low.
- rx_act  in  1  high for the whole duration of a received packet.
- rx_val  in  1  rx_dat valid this cycle; only meaningful while rx_act=1.
- rx_dat  in  8  payload byte.
- rx_pktval  in  1  one-cycle "packet good" (CRC ok) strobe, any cycle while rx_act=1 or in the cycle rx_act falls.
- fifo_wrnum  in  ASIZE+1  FIFO occupancy.
- fifo_full  in  1  FIFO full.
- fifo_write  out  1  FIFO write strobe.
- fifo_wdat  out  8  FIFO write data.
- fifo_pktval  out  1  FIFO commit strobe.
- fifo_rxact  out  1  FIFO rewind trigger; equals rx_act combinationally.
- rx_ready  out  1  space for one MAXPKT packet.
- pkt_len  out  ASIZE+1  byte count of the last finished packet.
- pkt_ok  out  1  one-cycle strobe: packet committed.
- pkt_err  out  1  one-cycle strobe: packet dropped.
- ok_cnt  out  16  committed-packet counter.
- drop_cnt  out  16  dropped-packet counter.

## Operation
- States: IDLE, RECV, FLUSH1, FLUSH2, END.
- IDLE → RECV when rx_act=1. In RECV, rx_act=0 → FLUSH1 → FLUSH2 → END → IDLE, each one cycle.
- Write pipe has two register stages, so a byte with rx_val at cycle t produces fifo_write/fifo_wdat during cycle t+2.
  - The delay guarantees the FIFO's rewind (at the end of the cycle after the rx_act rise) precedes the first write.
- Byte acceptance in RECV: a byte is accepted when rx_val=1 and cnt<MAXPKT; cnt increments and the byte enters the pipe.
  - rx_val with cnt=MAXPKT sets err; the byte is discarded.
- rx_val in IDLE or FLUSH/END is ignored.
- Stage 2 issues fifo_write only if fifo_full=0. If fifo_full=1, the write is suppressed and err is set.
- good flag: set by rx_pktval in RECV, or in the IDLE→RECV cycle.
- Clearing: cnt, err and good clear on IDLE→RECV.
- END outputs:
  - If good=1 and err=0: fifo_pktval=1 and pkt_ok=1, ok_cnt++.
  - Otherwise: pkt_err=1, drop_cnt++, and no fifo_pktval.
  - In both cases pkt_len←cnt.
- Zero-length good packet: commits with pkt_len=0 (a harmless pktval).
- rx_act rising during FLUSH1/FLUSH2/END is a protocol violation.
  - The current packet completes normally.
  - The new packet's bytes are ignored until the FSM re-enters RECV from IDLE, and that packet is forced err=1.
- rx_ready: registered; rx_ready ← (2^ASIZE − fifo_wrnum) ≥ MAXPKT, evaluated every cycle in ASIZE+2-bit arithmetic.
- Counters saturate at 16'hFFFF.

## Timing
- Reset values: all outputs 0, except fifo_rxact, which follows rx_act. State is IDLE; pipe, cnt, err and good are cleared.
- Byte to FIFO write latency: 2 cycles.
- rx_act fall (first cycle low, observed in RECV) to fifo_pktval: 3 cycles (FLUSH1, FLUSH2, END).
  - This ensures the last write, at most 1 cycle after the fall, has updated the FIFO write pointer before commit.
- fifo_pktval, pkt_ok and pkt_err are single-cycle strobes in END. Exactly one of pkt_ok/pkt_err fires per packet.
- rx_ready lags fifo_wrnum by 1 cycle.
- RSTn assertion mid-packet:
  - State returns immediately to IDLE, pipe writes are flushed, and no commit is issued.
  - Bytes already written to the FIFO are discarded by the FIFO's own reset or its next rewind.

## Configuration
- RX_STAT_CNT_EN defined: ok_cnt and drop_cnt are live saturating counters, cleared only by RSTn.
- RX_STAT_CNT_EN undefined: the counter registers are not built, and ok_cnt/drop_cnt are tied to 16'h0000. All other behaviour is identical.

## Test plan
- Good packet, 10 bytes 0x01..0x0A, rx_pktval at the last byte:
  - fifo_write pulses 10 times carrying 0x01..0x0A, each 2 cycles after its rx_val.
  - fifo_pktval fires 3 cycles after rx_act falls; pkt_ok=1, pkt_len=10, ok_cnt=1.
- Bad CRC, 8 bytes, no rx_pktval:
  - 8 writes, then pkt_err=1, no fifo_pktval, drop_cnt=1.
  - On the next packet, the FIFO rewinds before the first write; FIFO readback shows only committed data.
- Oversize, MAXPKT=64, 70 bytes with rx_pktval:
  - Exactly 64 writes, then pkt_err=1, pkt_len=64, no commit.
- FIFO full mid-packet (force fifo_full=1 after 5 writes):
  - Writes stop, pkt_err=1 at END.
- rx_ready with ASIZE=9, MAXPKT=64:
  - fifo_wrnum=448 → rx_ready=1.
  - fifo_wrnum=449 → rx_ready=0, one cycle later.
- Back-to-back violation: rx_act rises in FLUSH2:
  - The first packet commits (pkt_ok).
  - The second packet ends with pkt_err and no fifo_pktval.
  - With RX_STAT_CNT_EN undefined, ok_cnt and drop_cnt stay 0.
